// File: rtl/lynxTypes.sv
// Shared type definitions for the lynx datapath blocks.
package lynxTypes;

  localparam int unsigned AXI_DATA_BITS = 512;

  // Stability filter FSM states.
  typedef enum logic [0:0] {
    ST_STABLE,
    ST_SETTLE
  } stable_state_t;

endpackage

// File: rtl/logic_sat_cnt.sv
// Generic up-counter that holds at all-ones instead of wrapping.
module logic_sat_cnt #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_d, cnt_q;

  // Next count: step by one unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/logic_stable_filter.sv
// Stability filter placed after a bitwise CDC synchroniser. A new bus value is
// committed to m_data only after it has been sampled unchanged for STABLE_CYCLES
// consecutive cycles, hiding inter-bit skew. Each commit raises a valid/ready
// change event; a newer commit while an event is pending coalesces into it.
// Optional: define LOGIC_STABLE_STATS_EN to add a saturating glitch_cnt output
// counting candidate restarts during settling.
module logic_stable_filter
  import lynxTypes::*;
#(
  parameter int unsigned DATA_BITS     = AXI_DATA_BITS,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [DATA_BITS-1:0] s_data,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_evt_valid,
  input  logic                 m_evt_ready,
  output logic                 m_settling
`ifdef LOGIC_STABLE_STATS_EN
  ,
  output logic [31:0]          glitch_cnt
`endif
);

  localparam int unsigned CNT_BITS = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] CntLast = CNT_BITS'(STABLE_CYCLES - 1);
  // Idle value: one past the last settle step, so the counter never wraps.
  localparam logic [CNT_BITS-1:0] CntIdle = CNT_BITS'(STABLE_CYCLES);

  logic [DATA_BITS-1:0] s_d, s_q;
  logic [DATA_BITS-1:0] cand_d, cand_q;
  logic [DATA_BITS-1:0] m_data_d, m_data_q;
  logic [CNT_BITS-1:0]  cnt_d, cnt_q;
  logic                 evt_valid_d, evt_valid_q;
  stable_state_t        state_d, state_q;

  // Next-state logic for the settle FSM, candidate, counter and event flag.
  always_comb begin
    s_d         = s_data;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    m_data_d    = m_data_q;
    state_d     = state_q;
    // Handshake clears a pending event; a commit below overrides this.
    evt_valid_d = evt_valid_q && !m_evt_ready;

    unique case (state_q)
      ST_STABLE: begin
        if (s_q != cand_q) begin
          cand_d  = s_q;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (s_q != cand_q) begin
          // Input moved again before settling: restart on the new value.
          cand_d = s_q;
          cnt_d  = '0;
        end else if (cnt_q == CntLast) begin
          cnt_d   = CntIdle;
          state_d = ST_STABLE;
          // A bounce back to the committed value completes silently.
          if (cand_q != m_data_q) begin
            m_data_d    = cand_q;
            evt_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      s_q         <= '0;
      cand_q      <= '0;
      cnt_q       <= CntIdle;
      m_data_q    <= '0;
      evt_valid_q <= 1'b0;
      state_q     <= ST_STABLE;
    end else begin
      s_q         <= s_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      m_data_q    <= m_data_d;
      evt_valid_q <= evt_valid_d;
      state_q     <= state_d;
    end
  end

  assign m_data      = m_data_q;
  assign m_evt_valid = evt_valid_q;
  assign m_settling  = (state_q == ST_SETTLE);

`ifdef LOGIC_STABLE_STATS_EN
  logic glitch;

  // Only restarts inside SETTLE count; entry from STABLE is not a glitch.
  assign glitch = (state_q == ST_SETTLE) && (s_q != cand_q);

  logic_sat_cnt #(
    .WIDTH (32)
  ) u_glitch_cnt (
    .aclk   (aclk),
    .areset (areset),
    .inc    (glitch),
    .cnt    (glitch_cnt)
  );
`endif

endmodule

// File: tb/tb_logic_stable_filter.sv
// Self-checking bench for logic_stable_filter (DATA_BITS=8, STABLE_CYCLES=4).
// Directed scenarios followed by random stimulus, all compared every cycle
// against a run-length reference model.
module tb_logic_stable_filter;

  localparam int unsigned N = 4;

  logic       aclk = 1'b0;
  logic       areset;
  logic [7:0] s_data;
  logic [7:0] m_data;
  logic       m_evt_valid;
  logic       m_evt_ready;
  logic       m_settling;
`ifdef LOGIC_STABLE_STATS_EN
  logic [31:0] glitch_cnt;
`endif

  logic_stable_filter #(
    .DATA_BITS     (8),
    .STABLE_CYCLES (N)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .s_data      (s_data),
    .m_data      (m_data),
    .m_evt_valid (m_evt_valid),
    .m_evt_ready (m_evt_ready),
    .m_settling  (m_settling)
`ifdef LOGIC_STABLE_STATS_EN
    ,
    .glitch_cnt  (glitch_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  // Reference model: the filter registers one sample, then tracks how many
  // consecutive identical samples it has seen. A run that reaches N+1 equal
  // samples is accepted. run > N means "settled / idle".
  logic [7:0]  mod_sample;
  logic [7:0]  mod_prev;
  int          mod_run;
  logic [7:0]  mod_data;
  logic        mod_evt;
`ifdef LOGIC_STABLE_STATS_EN
  logic [31:0] mod_glitch;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task model_step();
    logic [7:0] x;
    logic       commit;
    if (areset) begin
      mod_sample = 8'h00;
      mod_prev   = 8'h00;
      mod_run    = N + 1;
      mod_data   = 8'h00;
      mod_evt    = 1'b0;
`ifdef LOGIC_STABLE_STATS_EN
      mod_glitch = 32'd0;
`endif
    end else begin
      x      = mod_sample;
      commit = 1'b0;
      if (x != mod_prev) begin
`ifdef LOGIC_STABLE_STATS_EN
        if (mod_run <= N && mod_glitch != 32'hFFFF_FFFF) mod_glitch = mod_glitch + 32'd1;
`endif
        mod_run  = 1;
        mod_prev = x;
      end else if (mod_run <= N) begin
        mod_run = mod_run + 1;
        if (mod_run == N + 1 && x != mod_data) commit = 1'b1;
      end
      if (commit) begin
        mod_data = x;
        mod_evt  = 1'b1;
      end else if (mod_evt && m_evt_ready) begin
        mod_evt = 1'b0;
      end
      mod_sample = s_data;
    end
  endtask

  // One clock: drive inputs, update the model at the edge, check #1 later.
  task automatic cycle(input logic r, input logic [7:0] d, input logic rd);
    areset      = r;
    s_data      = d;
    m_evt_ready = rd;
    @(posedge aclk);
    model_step();
    #1;
    chk("m_data", 32'(m_data), 32'(mod_data));
    chk("m_evt_valid", 32'(m_evt_valid), 32'(mod_evt));
    chk("m_settling", 32'(m_settling), 32'(mod_run <= N));
`ifdef LOGIC_STABLE_STATS_EN
    chk("glitch_cnt", glitch_cnt, mod_glitch);
`endif
  endtask

  initial begin
    logic [7:0] s;
    logic       rdy;
    logic       rst;

    // Reset, then quiet zero input.
    cycle(1'b1, 8'h00, 1'b1);
    cycle(1'b1, 8'h00, 1'b1);
    chk("reset_m_data", 32'(m_data), 32'h0);
    chk("reset_evt", 32'(m_evt_valid), 32'h0);
    chk("reset_settling", 32'(m_settling), 32'h0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("idle_settling", 32'(m_settling), 32'h0);

    // Plain change: commit at edge t+5, event cleared at t+6.
    cycle(1'b0, 8'h5A, 1'b1);               // edge t
    for (int i = 0; i < 4; i++) begin       // edges t+1..t+4
      cycle(1'b0, 8'h5A, 1'b1);
      chk("pre_commit_data", 32'(m_data), 32'h00);
    end
    cycle(1'b0, 8'h5A, 1'b1);               // edge t+5
    chk("commit_5a_data", 32'(m_data), 32'h5A);
    chk("commit_5a_evt", 32'(m_evt_valid), 32'h1);
    cycle(1'b0, 8'h5A, 1'b1);               // edge t+6
    chk("commit_5a_clear", 32'(m_evt_valid), 32'h0);

    // Skewed arrival: 58 for two samples then A5; commit at edge t+7.
    cycle(1'b0, 8'h58, 1'b1);               // edge t
    cycle(1'b0, 8'h58, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'hA5, 1'b1);   // edges t+2..t+5
    cycle(1'b0, 8'hA5, 1'b1);               // edge t+6
    chk("skew_pre_data", 32'(m_data), 32'h5A);
    cycle(1'b0, 8'hA5, 1'b1);               // edge t+7
    chk("skew_commit", 32'(m_data), 32'hA5);
`ifdef LOGIC_STABLE_STATS_EN
    chk("skew_glitch_cnt", glitch_cnt, 32'd1);
`endif
    cycle(1'b0, 8'hA5, 1'b1);

    // Coalescing with consumer stalled.
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h11, 1'b0);
    chk("coalesce_11", 32'(m_data), 32'h11);
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h22, 1'b0);
    chk("coalesce_22", 32'(m_data), 32'h22);
    chk("coalesce_evt", 32'(m_evt_valid), 32'h1);
    cycle(1'b0, 8'h22, 1'b1);
    chk("handshake_clear", 32'(m_evt_valid), 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h22, 1'b1);
    chk("single_handshake", 32'(m_evt_valid), 32'h0);

    // Bounce back to the committed value: settles but no commit.
    cycle(1'b0, 8'h33, 1'b1);
    cycle(1'b0, 8'h33, 1'b1);
    cycle(1'b0, 8'h22, 1'b1);
    chk("bounce_settling", 32'(m_settling), 32'h1);
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h22, 1'b1);
    chk("bounce_data", 32'(m_data), 32'h22);
    chk("bounce_evt", 32'(m_evt_valid), 32'h0);
    chk("bounce_idle", 32'(m_settling), 32'h0);

    // Reset while settling on 77, then let 77 commit after release.
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h77, 1'b0);
    cycle(1'b1, 8'h77, 1'b0);
    chk("midreset_data", 32'(m_data), 32'h0);
    chk("midreset_evt", 32'(m_evt_valid), 32'h0);
    chk("midreset_settling", 32'(m_settling), 32'h0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h77, 1'b0);
    chk("post_reset_wait", 32'(m_data), 32'h0);
    cycle(1'b0, 8'h77, 1'b0);
    chk("post_reset_commit", 32'(m_data), 32'h77);
    chk("post_reset_evt", 32'(m_evt_valid), 32'h1);

    // Random stimulus: sticky input values, random ready, rare resets.
    s = 8'h77;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(5) == 0) begin
        case ($urandom_range(3))
          0:       s = 8'h00;
          1:       s = 8'hFF;
          2:       s = 8'h5A;
          default: s = 8'($urandom);
        endcase
      end
      rdy = 1'($urandom_range(1));
      rst = ($urandom_range(299) == 0);
      cycle(rst, s, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
